// File: rtl/axi_decerr_slave_pkg.sv
// Shared SoC definitions for the AXI default-slave responder.
// Response codes, error data pattern, slave-side ID type and FSM states.
package axi_decerr_slave_pkg;

    localparam int unsigned IdWidthMaster = 4;
    localparam int unsigned NumMasters    = 2;
    localparam int unsigned IdWidthSlave  =
        IdWidthMaster + $clog2(NumMasters);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecerr = 2'b11;

    localparam logic [63:0] ErrDataDefault = 64'hBADC_AB1E_DEAD_BEEF;

    typedef logic [IdWidthSlave-1:0] slv_id_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_decerr_read_path.sv
// Read side of the default slave: accepts one AR at a time and
// returns ar_len+1 DECERR beats carrying a fixed data pattern.
module axi_decerr_read_path
    import axi_decerr_slave_pkg::*;
#(
    parameter int unsigned IdWidth   = IdWidthSlave,
    parameter int unsigned DataWidth = 64,
    parameter logic [DataWidth-1:0] ErrData = ErrDataDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o
);

    r_state_e             state;
    r_state_e             state_next;
    logic [7:0]           beat_cnt;
    logic [IdWidth-1:0]   id_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= R_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave IDLE on AR handshake, return after last beat
    always_comb begin
        state_next = state;
        unique case (state)
            R_IDLE: if (ar_valid_i) state_next = R_DATA;
            R_DATA: if (r_ready_i && beat_cnt == 8'd0) state_next = R_IDLE;
            default: state_next = R_IDLE;
        endcase
    end

    // Latch ID and remaining-beat count; count down on each R handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt <= '0;
            id_q     <= '0;
        end else if (state == R_IDLE && ar_valid_i) begin
            beat_cnt <= ar_len_i;
            id_q     <= ar_id_i;
        end else if (state == R_DATA && r_ready_i && beat_cnt != 8'd0) begin
            beat_cnt <= beat_cnt - 8'd1;
        end
    end

    // Channel outputs decoded from state
    always_comb begin
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_resp_o   = RespOkay;
        r_last_o   = 1'b0;
        r_data_o   = '0;
        unique case (state)
            R_IDLE: ar_ready_o = 1'b1;
            R_DATA: begin
                r_valid_o = 1'b1;
                r_resp_o  = RespDecerr;
                r_last_o  = (beat_cnt == 8'd0);
                r_data_o  = ErrData;
            end
            default: ar_ready_o = 1'b0;
        endcase
    end

    assign r_id_o = id_q;

endmodule

// File: rtl/axi_decerr_slave.sv
// AXI4 default slave: answers unmapped accesses with DECERR and
// records the first offending address plus a saturating error count.
module axi_decerr_slave
    import axi_decerr_slave_pkg::*;
#(
    parameter int unsigned IdWidth   = IdWidthSlave,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter logic [DataWidth-1:0] ErrData = ErrDataDefault,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic                 err_valid_o,
    output logic                 err_is_write_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [CntWidth-1:0]  err_count_o,
    input  logic                 err_clear_i
);

    w_state_e             w_state;
    w_state_e             w_state_next;
    logic [IdWidth-1:0]   aw_id_q;
    logic                 aw_hs;
    logic                 ar_hs;
    logic                 valid_base;
    logic [CntWidth-1:0]  cnt_base;
    logic [CntWidth:0]    cnt_sum;
    logic [CntWidth-1:0]  cnt_next;

    axi_decerr_read_path #(
        .IdWidth   (IdWidth),
        .DataWidth (DataWidth),
        .ErrData   (ErrData)
    ) u_read_path (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .ar_id_i    (ar_id_i),
        .ar_len_i   (ar_len_i),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .r_id_o     (r_id_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_last_o   (r_last_o)
    );

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign ar_hs = ar_valid_i & ar_ready_o;

    // Write state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    // Write next-state: AW, drain W to last, then hold B until taken
    always_comb begin
        w_state_next = w_state;
        unique case (w_state)
            W_IDLE: if (aw_valid_i) w_state_next = W_DATA;
            W_DATA: if (w_valid_i && w_last_i) w_state_next = W_RESP;
            W_RESP: if (b_ready_i) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write channel outputs decoded from state
    always_comb begin
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        b_resp_o   = RespOkay;
        unique case (w_state)
            W_IDLE: aw_ready_o = 1'b1;
            W_DATA: w_ready_o  = 1'b1;
            W_RESP: begin
                b_valid_o = 1'b1;
                b_resp_o  = RespDecerr;
            end
            default: aw_ready_o = 1'b0;
        endcase
    end

    // Latch the write ID on AW handshake for the B response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_id_q <= '0;
        end else if (aw_hs) begin
            aw_id_q <= aw_id_i;
        end
    end

    assign b_id_o = aw_id_q;

    // Clear takes effect before this cycle's capture and count
    always_comb begin
        valid_base = err_clear_i ? 1'b0 : err_valid_o;
        cnt_base   = err_clear_i ? '0 : err_count_o;
        cnt_sum    = {1'b0, cnt_base}
                   + {{CntWidth{1'b0}}, aw_hs}
                   + {{CntWidth{1'b0}}, ar_hs};
        cnt_next   = cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
    end

    // First-error capture (write wins a tie) and saturating count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_valid_o    <= 1'b0;
            err_is_write_o <= 1'b0;
            err_addr_o     <= '0;
            err_count_o    <= '0;
        end else begin
            err_count_o <= cnt_next;
            err_valid_o <= valid_base | aw_hs | ar_hs;
            if (!valid_base && (aw_hs || ar_hs)) begin
                err_is_write_o <= aw_hs;
                err_addr_o     <= aw_hs ? aw_addr_i : ar_addr_i;
            end
        end
    end

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Scoreboard bench for the AXI default slave.
// Expected R/B responses are queued at issue and popped on handshake.
module tb_axi_decerr_slave;

    localparam logic [63:0] ErrPat = 64'hBADC_AB1E_DEAD_BEEF;

    typedef struct {
        logic [4:0] id;
        logic       last;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        aw_valid;
    logic        aw_ready;
    logic [4:0]  aw_id;
    logic [63:0] aw_addr;
    logic        w_valid;
    logic        w_ready;
    logic        w_last;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid;
    logic        ar_ready;
    logic [4:0]  ar_id;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic        r_valid;
    logic        r_ready;
    logic [4:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        err_valid;
    logic        err_is_write;
    logic [63:0] err_addr;
    logic [3:0]  err_count;
    logic        err_clear;

    rexp_t       rq[$];
    logic [4:0]  bq[$];
    int          checks = 0;
    int          errors = 0;
    int          rbeats = 0;
    int          rr_mode = 0;

    logic        hold_v = 1'b0;
    logic [4:0]  h_id;
    logic [63:0] h_data;
    logic        h_last;
    logic [1:0]  h_resp;

    always #5 clk = ~clk;

    axi_decerr_slave #(
        .IdWidth   (5),
        .AddrWidth (64),
        .DataWidth (64),
        .ErrData   (ErrPat),
        .CntWidth  (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .aw_valid_i     (aw_valid),
        .aw_ready_o     (aw_ready),
        .aw_id_i        (aw_id),
        .aw_addr_i      (aw_addr),
        .w_valid_i      (w_valid),
        .w_ready_o      (w_ready),
        .w_last_i       (w_last),
        .b_valid_o      (b_valid),
        .b_ready_i      (b_ready),
        .b_id_o         (b_id),
        .b_resp_o       (b_resp),
        .ar_valid_i     (ar_valid),
        .ar_ready_o     (ar_ready),
        .ar_id_i        (ar_id),
        .ar_addr_i      (ar_addr),
        .ar_len_i       (ar_len),
        .r_valid_o      (r_valid),
        .r_ready_i      (r_ready),
        .r_id_o         (r_id),
        .r_data_o       (r_data),
        .r_resp_o       (r_resp),
        .r_last_o       (r_last),
        .err_valid_o    (err_valid),
        .err_is_write_o (err_is_write),
        .err_addr_o     (err_addr),
        .err_count_o    (err_count),
        .err_clear_i    (err_clear)
    );

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // R ready pattern: 0 hold high, 1 toggle, 2 hold low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       r_ready = 1'b1;
                1:       r_ready = ~r_ready;
                default: r_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop expectations on handshakes, check hold while stalled
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("r_hold_valid", r_valid, 1'b1);
                chk("r_hold_id", r_id, h_id);
                chk("r_hold_data", r_data, h_data);
                chk("r_hold_last", r_last, h_last);
                chk("r_hold_resp", r_resp, h_resp);
            end
            hold_v = r_valid & ~r_ready;
            h_id   = r_id;
            h_data = r_data;
            h_last = r_last;
            h_resp = r_resp;
            if (r_valid && r_ready) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected", rq.size(), 1);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("r_id", r_id, e.id);
                    chk("r_data", r_data, ErrPat);
                    chk("r_resp", r_resp, 2'b11);
                    chk("r_last", r_last, e.last);
                    rbeats++;
                end
            end
            if (b_valid && b_ready) begin
                if (bq.size() == 0) begin
                    chk("b_unexpected", bq.size(), 1);
                end else begin
                    chk("b_id", b_id, bq.pop_front());
                    chk("b_resp", b_resp, 2'b11);
                end
            end
        end
    end

    task automatic send_ar(logic [4:0] id, logic [63:0] addr,
                           logic [7:0] len);
        int   t = 0;
        logic hs;
        rexp_t e;
        ar_valid = 1'b1;
        ar_id    = id;
        ar_addr  = addr;
        ar_len   = len;
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = id;
            e.last = (i == int'(len));
            rq.push_back(e);
        end
        do begin
            @(negedge clk);
            hs = ar_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 1000);
        chk("ar_handshake", hs, 1'b1);
        ar_valid = 1'b0;
    endtask

    task automatic send_aw(logic [4:0] id, logic [63:0] addr);
        int   t = 0;
        logic hs;
        aw_valid = 1'b1;
        aw_id    = id;
        aw_addr  = addr;
        bq.push_back(id);
        do begin
            @(negedge clk);
            hs = aw_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 1000);
        chk("aw_handshake", hs, 1'b1);
        aw_valid = 1'b0;
    endtask

    task automatic send_w(int n);
        for (int i = 0; i < n; i++) begin
            int   t = 0;
            logic hs;
            w_valid = 1'b1;
            w_last  = (i == n - 1);
            do begin
                @(negedge clk);
                hs = w_ready;
                @(posedge clk);
                #1;
                t++;
            end while (!hs && t < 1000);
            chk("w_handshake", hs, 1'b1);
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_done", rq.size() + bq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        int n;
        rst = 1'b1;
        aw_valid = 1'b0; aw_id = '0; aw_addr = '0;
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
        ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0;
        r_ready = 1'b1; err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_aw_ready", aw_ready, 1'b1);
        chk("rst_ar_ready", ar_ready, 1'b1);
        chk("rst_w_ready", w_ready, 1'b0);
        chk("rst_b_valid", b_valid, 1'b0);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_b_id", b_id, 5'h0);
        chk("rst_r_id", r_id, 5'h0);
        chk("rst_err_valid", err_valid, 1'b0);
        chk("rst_err_addr", err_addr, 64'h0);
        chk("rst_err_count", err_count, 4'h0);
        rst = 1'b0;

        // W presented before AW is stalled
        w_valid = 1'b1;
        w_last  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("w_stall", w_ready, 1'b0);
        send_aw(5'h13, 64'h3000_0000);
        chk("b_not_early", b_valid, 1'b0);
        send_w(1);
        chk("b_latency", b_valid, 1'b1);
        chk("wr_err_addr", err_addr, 64'h3000_0000);
        chk("wr_err_is_write", err_is_write, 1'b1);
        chk("wr_err_count", err_count, 4'd1);
        chk("wr_err_valid", err_valid, 1'b1);
        drain();

        // Read burst with toggling ready
        clr();
        rr_mode = 1;
        send_ar(5'h07, 64'h4000_0000, 8'd3);
        chk("ar_latency", r_valid, 1'b1);
        drain();
        rr_mode = 0;
        chk("rd_idle", r_valid, 1'b0);
        chk("rd_err_addr", err_addr, 64'h4000_0000);
        chk("rd_err_is_write", err_is_write, 1'b0);
        chk("rd_err_count", err_count, 4'd1);

        // Concurrent AW and AR
        clr();
        fork
            send_aw(5'h0A, 64'h5000_0000);
            send_ar(5'h1C, 64'h6000_0000, 8'd0);
        join
        send_w(4);
        drain();
        chk("cc_err_is_write", err_is_write, 1'b1);
        chk("cc_err_addr", err_addr, 64'h5000_0000);
        chk("cc_err_count", err_count, 4'd2);

        // Counter saturation, then clear together with a handshake
        clr();
        for (int k = 0; k < 17; k++) begin
            send_ar(5'(k), 64'h7000_0000 + 64'(k * 64), 8'd0);
        end
        drain();
        chk("sat_count", err_count, 4'd15);
        chk("sat_err_addr", err_addr, 64'h7000_0000);
        err_clear = 1'b1;
        send_ar(5'h11, 64'hA000_0000, 8'd0);
        err_clear = 1'b0;
        chk("clr_hs_count", err_count, 4'd1);
        chk("clr_hs_valid", err_valid, 1'b1);
        chk("clr_hs_addr", err_addr, 64'hA000_0000);
        chk("clr_hs_is_write", err_is_write, 1'b0);
        drain();

        // Reset in the middle of a long burst
        rr_mode = 0;
        base = rbeats;
        send_ar(5'h02, 64'hB000_0000, 8'd255);
        t = 0;
        while (rbeats < base + 10 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("mid_beats", rbeats, base + 10);
        rst = 1'b1;
        rr_mode = 2;
        r_ready = 1'b0;
        @(posedge clk);
        #1;
        rq.delete();
        chk("mid_rst_r_valid", r_valid, 1'b0);
        chk("mid_rst_ar_ready", ar_ready, 1'b1);
        chk("mid_rst_count", err_count, 4'd0);
        chk("mid_rst_err_valid", err_valid, 1'b0);
        rst = 1'b0;
        rr_mode = 0;
        send_ar(5'h03, 64'hB100_0000, 8'd0);
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_beats", rbeats, base + 11);
        chk("post_rst_idle", r_valid, 1'b0);

        // Maximum burst at full rate
        send_ar(5'h04, 64'hC000_0000, 8'd255);
        chk("max_ar_latency", r_valid, 1'b1);
        n = 0;
        while (rq.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("max_burst_cycles", n, 256);
        chk("max_burst_idle", r_valid, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_decerr_slave.md
Name: axi_decerr_slave

Overview:
- AXI4 responder that terminates every transaction the SoC crossbar routes to an unmapped address, so masters never hang on a hole in the memory map.
- Sits on the default (no-rule-match) port of the crossbar, on the slave side, so it uses the widened slave-side ID.
- Write and read paths are independent: writes drain all W beats and answer with one DECERR B; reads return ar_len+1 DECERR beats carrying a fixed pattern.
- Captures the first offending address and keeps a saturating error count for debug.

Parameters:
IdWidth, 5, slave-side AXI ID width (master ID width 4 + log2 of 2 crossbar masters)
AddrWidth, 64, AXI address width
DataWidth, 64, AXI data width
ErrData, 64'hBADC_AB1E_DEAD_BEEF, R data returned on every error beat
CntWidth, 16, width of the saturating error counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
aw_valid_i  in  1  AW valid
aw_ready_o  out  1  AW ready
aw_id_i  in  IdWidth  AW ID
aw_addr_i  in  AddrWidth  AW address
w_valid_i  in  1  W valid
w_ready_o  out  1  W ready
w_last_i  in  1  W last beat
b_valid_o  out  1  B valid
b_ready_i  in  1  B ready
b_id_o  out  IdWidth  B ID
b_resp_o  out  2  B response, always DECERR
ar_valid_i  in  1  AR valid
ar_ready_o  out  1  AR ready
ar_id_i  in  IdWidth  AR ID
ar_addr_i  in  AddrWidth  AR address
ar_len_i  in  8  AR burst length minus 1
r_valid_o  out  1  R valid
r_ready_i  in  1  R ready
r_id_o  out  IdWidth  R ID
r_data_o  out  DataWidth  R data, always ErrData
r_resp_o  out  2  R response, always DECERR
r_last_o  out  1  R last
err_valid_o  out  1  sticky flag: an error address has been captured
err_is_write_o  out  1  captured error came from the AW channel
err_addr_o  out  AddrWidth  captured error address
err_count_o  out  CntWidth  saturating count of accepted AW and AR requests
err_clear_i  in  1  clears err_valid_o and err_count_o

Behaviour:
- Clock and reset: one clock (clk_i). Synchronous, active-high reset (rst_i).
- Reset values:
  - FSMs go to IDLE.
  - aw_ready_o=1 and ar_ready_o=1; every other output is 0, including IDs, address and count.
  - r_data_o is ErrData whenever r_valid_o=1 and don't-care otherwise.
  - Reset asserted mid-transaction discards any in-flight burst or response. No B or R is issued for it.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready_o=1, w_ready_o=0. On aw_valid&aw_ready, latch aw_id and go to W_DATA.
  - W_DATA: aw_ready_o=0, w_ready_o=1. Consume beats; on a w handshake with w_last_i=1, go to W_RESP.
  - W_RESP: b_valid_o=1, b_id_o=latched ID, b_resp_o=2'b11. Hold stable until b_ready_i, then return to W_IDLE.
  - Earliest response: AW accepted in cycle N, single-beat W in N+1, b_valid in N+2.
  - W beats presented before AW are stalled (w_ready_o=0). Only one write is outstanding.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ar_ready_o=1. On handshake, latch ar_id and set beat counter to ar_len_i, then go to R_DATA.
  - R_DATA: ar_ready_o=0, r_valid_o=1, r_resp_o=2'b11, r_last_o=(counter==0).
  - On each r handshake the counter decrements. A handshake with r_last_o returns to R_IDLE.
  - AR accepted in cycle N gives first r_valid in N+1. With r_ready_i held high, the burst completes in ar_len+1 consecutive cycles.
  - ar_len_i=255 produces 256 beats; the counter is 8 bits and never wraps. R outputs hold stable while r_ready_i=0.
- Read and write paths are fully concurrent. Simultaneous AW and AR handshakes are both accepted.
- Error capture:
  - On an AW or AR handshake with err_valid_o=0, latch the address and err_is_write_o, and set err_valid_o.
  - If AW and AR handshake in the same cycle, the write address is captured.
  - err_count_o adds the number of handshakes in the cycle (0, 1 or 2) and saturates at all-ones without wrapping.
  - err_clear_i zeroes the count and err_valid_o. If a handshake occurs in the same cycle, the clear applies first, then that cycle's capture and count: err_valid_o=1 and count = 1 or 2 next cycle.

Decomposition:
- The shared SoC package gets:
  - the axi_resp constants OKAY=2'b00 and DECERR=2'b11;
  - ErrData as a named constant;
  - a typedef for the slave-side ID: logic [IdWidthSlave-1:0].
- One natural sub-module: axi_decerr_read_path, containing the read FSM and beat counter. It is instantiated once.
- The write FSM and error capture stay in the top.

Test Plan:
- Write path: AW id=5'h13 addr=64'h3000_0000, then one W beat with last=1, b_ready=1 -> b_valid in cycle N+2, b_id=5'h13, b_resp=2'b11, err_addr_o=64'h3000_0000, err_is_write_o=1, err_count_o=1.
- Read burst with backpressure: AR id=5'h07 len=3, r_ready toggling 1,0,1,... -> exactly 4 beats, data=ErrData, resp=2'b11, r_last only on the 4th; outputs stable while r_ready=0.
- Concurrency: AW (4-beat W) and AR (len=0) accepted in the same cycle -> both complete independently, err_is_write_o=1, err_count_o=2.
- Saturation and clear: CntWidth=4, issue 17 single reads -> count stays at 15. Then err_clear_i together with a new AR handshake -> next cycle count=1, err_valid_o=1, new address captured.
- Reset mid-burst: AR len=255, reset asserted after beat 10 -> next cycle r_valid_o=0, ar_ready_o=1, count=0. A new AR len=0 then returns exactly 1 beat.
- Max burst: AR len=255 with r_ready held high -> 256 beats in consecutive cycles, r_last only on beat 256.
